round_controller: RTL and testbench
===================================

// Module: round_controller
// PURPOSE
//  Game-round sequencer for the 1 Hz countdown timer datapath (rate divider + seconds counter).
//  Decides when the timer is loaded, with what value, and when it runs.
//  Tracks level, lives and score, and raises fail/win to the display and top level.
//  Sits between the player buttons and the timer; the timer's zero flag feeds back in.
// PARAMETERS
//  BASE_TIME  59  seconds loaded at level 0 (6-bit, 1..63)
//  STEP_TIME  5   seconds removed per level
//  MIN_TIME   10  floor on the loaded time (1..BASE_TIME)
//  MAX_LEVEL  7   last level; a hit at this level wins (0..15)
//  LIVES      3   timeouts allowed per game (1..3)
// PORTS
//  clk             in   1  system clock
//  reset_n         in   1  asynchronous active-low reset
//  start           in   1  start/restart button, synchronous level; rising edge acts
//  pause           in   1  pause toggle button, synchronous level; rising edge acts
//  hit             in   1  player success, synchronous level; rising edge acts
//  time_zero       in   1  timer value == 0
//  timer_load      out  1  one-cycle load strobe to the timer
//  timer_load_val  out  6  value to load, valid while timer_load=1
//  timer_run       out  1  timer decrement enable (ANDed with 1 Hz tick in the timer)
//  level           out  4  current level
//  lives           out  2  lives remaining
//  score           out  8  hits this game, saturating
//  state           out  3  FSM state code, for debug/LEDs
//  fail            out  1  game lost, held
//  win             out  1  game won, held
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, level=0, lives=LIVES, score=0.
//    All strobes/flags=0, timer_load_val=0, edge-detect regs=0.
//  - Edge detect: x_pulse = x & ~x_q, with x_q registered each clk. Held buttons act once.
//  - States: IDLE=0, LOAD=1, RUN=2, PAUSE=3, LOST=4, WON=5. Codes 6/7 go to IDLE.
//  - Outputs are Moore, decoded from registered state. Latency: start_pulse at edge k
//    gives state=LOAD and timer_load=1 for exactly the cycle after k.
//  - IDLE: start_pulse -> LOAD; level=0, lives=LIVES, score=0.
//  - LOAD: timer_load=1, timer_load_val=T(level); always -> RUN next cycle.
//  - RUN: timer_run=1. Priority: hit_pulse > time_zero > pause_pulse.
//     hit_pulse: score+1 (saturates at 255). If level==MAX_LEVEL -> WON, else level+1 -> LOAD.
//     time_zero: lives-1. If lives==1 -> LOST (lives=0), else -> LOAD at the same level.
//     pause_pulse: -> PAUSE (PAUSE_EN only).
//  - PAUSE: timer_run=0. pause_pulse -> RUN. hit/start/time_zero ignored.
//  - LOST: fail=1. WON: win=1. Both hold until start_pulse -> LOAD with counters
//    reinitialised as in IDLE.
//  - start_pulse in LOAD/RUN/PAUSE is ignored (no mid-round restart).
//  - time_zero is sampled only in RUN.
//  - T(level) = BASE_TIME - level*STEP_TIME, saturating: if level*STEP_TIME >= BASE_TIME-MIN_TIME,
//    T = MIN_TIME. Use a 10-bit intermediate; never underflow.
//  - Reset mid-round: immediate return to the reset values; timer_run drops asynchronously.
// CONFIGURATION
//  PAUSE_EN defined: the pause input and the PAUSE state behave as above.
//  PAUSE_EN undefined: pause is ignored and the PAUSE state is unreachable (decodes to IDLE);
//    all other behaviour is identical.
// TESTING
//  1 reset then start pulse -> timer_load=1 for 1 cycle, timer_load_val=59, then timer_run=1, state=2.
//  2 hit in RUN at level 0 -> level=1, score=1, next load value 54; hits through level 7 -> win=1, state=5.
//  3 time_zero x3 at level 2 -> lives 2,1,0; reloads 49 twice, then fail=1, state=4, timer_run=0.
//  4 hit and time_zero in the same cycle -> hit wins: lives unchanged, level+1.
//  5 MAX_LEVEL=15, reach level 12 -> timer_load_val=10 (saturated); start held high 20 cycles -> one load only.
//  6 PAUSE_EN: pause in RUN -> timer_run=0, hit ignored, pause again -> RUN;
//    without PAUSE_EN -> state stays 2; reset_n low mid-RUN -> state=0, lives=3.

Source files
------------

// File: rtl/round_controller.sv
// round_controller: game-round sequencer for the 1 Hz countdown timer.
// Define PAUSE_EN to enable the pause button and the PAUSE state.
module round_controller #(
  parameter int unsigned BASE_TIME = 59,
  parameter int unsigned STEP_TIME = 5,
  parameter int unsigned MIN_TIME  = 10,
  parameter int unsigned MAX_LEVEL = 7,
  parameter int unsigned LIVES     = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause,
  input  logic       hit,
  input  logic       time_zero,
  output logic       timer_load,
  output logic [5:0] timer_load_val,
  output logic       timer_run,
  output logic [3:0] level,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [2:0] state,
  output logic       fail,
  output logic       win
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_LOST  = 3'd4,
    S_WON   = 3'd5
  } st_t;

  st_t st, st_nx;

  logic start_q, hit_q;
  logic start_p, hit_p, pause_p;
  logic last, restart;
  logic [9:0] drop;
  logic [5:0] load_time;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      start_q <= start;
      hit_q   <= hit;
    end
  end

  assign start_p = start & ~start_q;
  assign hit_p   = hit & ~hit_q;

`ifdef PAUSE_EN
  logic pause_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pause_q <= 1'b0;
    else          pause_q <= pause;
  end

  assign pause_p = pause & ~pause_q;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_p      = 1'b0;
`endif

  assign last    = (level == 4'(MAX_LEVEL));
  assign restart = start_p &
                   ((st == S_IDLE) | (st == S_LOST) | (st == S_WON));

  // 10-bit product so large levels saturate instead of wrapping
  assign drop      = 10'(level) * 10'(STEP_TIME);
  assign load_time = (drop >= 10'(BASE_TIME - MIN_TIME))
                   ? 6'(MIN_TIME)
                   : 6'(10'(BASE_TIME) - drop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st <= S_IDLE;
    else          st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      S_IDLE, S_LOST, S_WON: begin
        if (start_p) st_nx = S_LOAD;
      end
      S_LOAD: st_nx = S_RUN;
      S_RUN: begin
        if (hit_p)
          st_nx = last ? S_WON : S_LOAD;
        else if (time_zero)
          st_nx = (lives == 2'd1) ? S_LOST : S_LOAD;
        else if (pause_p)
          st_nx = S_PAUSE;
      end
`ifdef PAUSE_EN
      S_PAUSE: begin
        if (pause_p) st_nx = S_RUN;
      end
`endif
      default: st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
      lives <= 2'(LIVES);
      score <= '0;
    end else if (restart) begin
      level <= '0;
      lives <= 2'(LIVES);
      score <= '0;
    end else if (st == S_RUN) begin
      if (hit_p) begin
        if (score != 8'hff) score <= score + 8'd1;
        if (!last)          level <= level + 4'd1;
      end else if (time_zero) begin
        lives <= lives - 2'd1;
      end
    end
  end

  always_comb begin
    timer_load     = 1'b0;
    timer_load_val = '0;
    timer_run      = 1'b0;
    fail           = 1'b0;
    win            = 1'b0;
    unique case (st)
      S_LOAD: begin
        timer_load     = 1'b1;
        timer_load_val = load_time;
      end
      S_RUN:   timer_run = 1'b1;
      S_LOST:  fail      = 1'b1;
      S_WON:   win       = 1'b1;
      default: ;
    endcase
  end

  assign state = st;

endmodule

// File: tb/tb_round_controller.sv
// Testbench for round_controller: vector table, corner sequences,
// and randomized stimulus against a behavioural game model.
module tb_round_controller;

  localparam int BASE = 59;
  localparam int STEP = 5;
  localparam int MINT = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic hit = 1'b0;
  logic time_zero = 1'b0;

  logic       a_load, a_run, a_fail, a_win;
  logic [5:0] a_val;
  logic [3:0] a_level;
  logic [1:0] a_lives;
  logic [7:0] a_score;
  logic [2:0] a_state;

  logic       b_load, b_run, b_fail, b_win;
  logic [5:0] b_val;
  logic [3:0] b_level;
  logic [1:0] b_lives;
  logic [7:0] b_score;
  logic [2:0] b_state;

  logic [26:0] a_vec, b_vec;

  round_controller dut_a (
    .clk(clk), .reset_n(reset_n), .start(start),
    .pause(pause), .hit(hit), .time_zero(time_zero),
    .timer_load(a_load), .timer_load_val(a_val),
    .timer_run(a_run), .level(a_level), .lives(a_lives),
    .score(a_score), .state(a_state),
    .fail(a_fail), .win(a_win)
  );

  round_controller #(.MAX_LEVEL(15)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start),
    .pause(pause), .hit(hit), .time_zero(time_zero),
    .timer_load(b_load), .timer_load_val(b_val),
    .timer_run(b_run), .level(b_level), .lives(b_lives),
    .score(b_score), .state(b_state),
    .fail(b_fail), .win(b_win)
  );

  always #5 clk = ~clk;

  assign a_vec = {a_load, a_val, a_run, a_level, a_lives,
                  a_score, a_state, a_fail, a_win};
  assign b_vec = {b_load, b_val, b_run, b_level, b_lives,
                  b_score, b_state, b_fail, b_win};

  typedef struct {
    int st;
    int level;
    int lives;
    int score;
    bit sq;
    bit pq;
    bit hq;
  } model_t;

  typedef struct {
    bit s;
    bit h;
    bit tz;
    int st;
    int lvl;
    int lv;
    int sc;
    int val;
  } vec_t;

  model_t ma, mb;
  vec_t tbl [18];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int t_of(int lvl);
    int t;
    t = BASE - lvl * STEP;
    return (t < MINT) ? MINT : t;
  endfunction

  function automatic model_t m_reset();
    model_t m;
    m.st = 0; m.level = 0; m.lives = 3; m.score = 0;
    m.sq = 0; m.pq = 0; m.hq = 0;
    return m;
  endfunction

  function automatic model_t step(model_t m, int maxl,
                                  bit s, bit p, bit h, bit tz);
    model_t n;
    bit sp, pp, hp;
    n  = m;
    sp = s && !m.sq;
    pp = p && !m.pq;
    hp = h && !m.hq;
`ifndef PAUSE_EN
    pp = 1'b0;
`endif
    n.sq = s; n.pq = p; n.hq = h;
    case (m.st)
      0, 4, 5: if (sp) begin
        n.st = 1; n.level = 0; n.lives = 3; n.score = 0;
      end
      1: n.st = 2;
      2: begin
        if (hp) begin
          n.score = (m.score < 255) ? m.score + 1 : 255;
          if (m.level == maxl) n.st = 5;
          else begin
            n.level = m.level + 1;
            n.st = 1;
          end
        end else if (tz) begin
          n.lives = m.lives - 1;
          n.st = (n.lives == 0) ? 4 : 1;
        end else if (pp) begin
          n.st = 3;
        end
      end
      3: if (pp) n.st = 2;
      default: n.st = 0;
    endcase
    return n;
  endfunction

  function automatic logic [26:0] pack(int st, int lvl, int lv,
                                       int sc, int val);
    return {st == 1, 6'(val), st == 2, 4'(lvl), 2'(lv),
            8'(sc), 3'(st), st == 4, st == 5};
  endfunction

  function automatic logic [26:0] pack_m(model_t m);
    return pack(m.st, m.level, m.lives, m.score,
                (m.st == 1) ? t_of(m.level) : 0);
  endfunction

  task automatic check(string name, logic [26:0] act,
                       logic [26:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_i(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      ma = step(ma, 7, start, pause, hit, time_zero);
      mb = step(mb, 15, start, pause, hit, time_zero);
    end else begin
      ma = m_reset();
      mb = m_reset();
    end
    #1;
    check("model_a", a_vec, pack_m(ma));
    check("model_b", b_vec, pack_m(mb));
  endtask

  initial begin
    int loads;
    tbl[0]  = '{1, 0, 0, 1, 0, 3, 0, 59};
    tbl[1]  = '{0, 0, 0, 2, 0, 3, 0, 0};
    tbl[2]  = '{0, 1, 0, 1, 1, 3, 1, 54};
    tbl[3]  = '{0, 0, 0, 2, 1, 3, 1, 0};
    tbl[4]  = '{0, 1, 0, 1, 2, 3, 2, 49};
    tbl[5]  = '{0, 0, 0, 2, 2, 3, 2, 0};
    tbl[6]  = '{0, 0, 1, 1, 2, 2, 2, 49};
    tbl[7]  = '{0, 0, 0, 2, 2, 2, 2, 0};
    tbl[8]  = '{0, 0, 1, 1, 2, 1, 2, 49};
    tbl[9]  = '{0, 0, 0, 2, 2, 1, 2, 0};
    tbl[10] = '{0, 1, 1, 1, 3, 1, 3, 44};
    tbl[11] = '{0, 0, 0, 2, 3, 1, 3, 0};
    tbl[12] = '{0, 0, 1, 4, 3, 0, 3, 0};
    tbl[13] = '{0, 0, 0, 4, 3, 0, 3, 0};
    tbl[14] = '{1, 0, 0, 1, 0, 3, 0, 59};
    tbl[15] = '{1, 0, 0, 2, 0, 3, 0, 0};
    tbl[16] = '{1, 0, 0, 2, 0, 3, 0, 0};
    tbl[17] = '{0, 0, 0, 2, 0, 3, 0, 0};

    ma = m_reset();
    mb = m_reset();
    tick();
    tick();
    check("reset", a_vec, pack(0, 0, 3, 0, 0));
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      start = tbl[i].s;
      hit = tbl[i].h;
      time_zero = tbl[i].tz;
      tick();
      check($sformatf("vec%0d", i), a_vec,
            pack(tbl[i].st, tbl[i].lvl, tbl[i].lv,
                 tbl[i].sc, tbl[i].val));
    end

    // climb to the win on dut_a, and past level 12 on dut_b
    for (int i = 1; i <= 12; i++) begin
      hit = 1'b1;
      tick();
      if (i == 8) begin
        check_i("win_flag", int'(a_win), 1);
        check_i("win_state", int'(a_state), 5);
        check_i("win_level", int'(a_level), 7);
        check_i("win_score", int'(a_score), 8);
      end
      if (i == 12) begin
        check_i("sat_level", int'(b_level), 12);
        check_i("sat_load", int'(b_load), 1);
        check_i("sat_val", int'(b_val), 10);
      end
      hit = 1'b0;
      tick();
    end

    start = 1'b1;
    loads = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      loads += int'(a_load);
    end
    check_i("held_start_loads", loads, 1);
    start = 1'b0;
    tick();

    pause = 1'b1;
    tick();
    pause = 1'b0;
`ifdef PAUSE_EN
    check_i("pause_state", int'(a_state), 3);
    check_i("pause_run", int'(a_run), 0);
    hit = 1'b1;
    tick();
    check_i("pause_hit_level", int'(a_level), 0);
    check_i("pause_hit_state", int'(a_state), 3);
    hit = 1'b0;
    pause = 1'b1;
    tick();
    check_i("unpause_state", int'(a_state), 2);
    pause = 1'b0;
`else
    check_i("nopause_state", int'(a_state), 2);
    check_i("nopause_run", int'(a_run), 1);
`endif
    tick();

    time_zero = 1'b1;
    tick();
    time_zero = 1'b0;
    tick();
    tick();
    check_i("pre_reset_lives", int'(a_lives), 2);
    #2;
    reset_n = 1'b0;
    #1;
    check_i("async_state", int'(a_state), 0);
    check_i("async_lives", int'(a_lives), 3);
    check_i("async_run", int'(a_run), 0);
    tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 11) == 0);
      hit = ($urandom_range(0, 3) == 0);
      pause = ($urandom_range(0, 7) == 0);
      time_zero = ($urandom_range(0, 5) == 0);
      reset_n = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
